keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/sync2.sv | 28 ++
 rtl/keypad_scanner.sv | 113 +++++++++++
 tb/tb_keypad_scanner.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// the row/column to hex-code map and single-key detection helpers.
package keypad_pkg;

    localparam int NCOLS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    // Indexed [row][col]; row 0 is the top row of the keypad.
    localparam logic [3:0] KEY_MAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic single_low(input logic [3:0] r);
        return ($countones(~r) == 1);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, with a
// configurable reset value so idle lines come up inactive.
module sync2 #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces a
// single pressed row, reports the key once and tracks hold/release.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_tick,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_TICKS - 1);

    logic [3:0]  rs;
    scan_state_t state_q, state_d;
    logic [1:0]  col_q, col_d;
    logic [1:0]  row_q, row_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  key_q, key_d;
    logic        kv_q, kv_d;
    logic        row_low;

    sync2 #(.W(4), .RST_VAL(4'hF)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rs)
    );

    // Once a row is captured only that row line matters; others are ignored.
    assign row_low = !rs[row_q];

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        kv_d    = 1'b0;
        if (scan_tick) begin
            unique case (state_q)
                SCAN: begin
                    if (single_low(rs)) begin
                        row_d   = low_index(rs);
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (row_low && cnt_q == CNT_LAST) begin
                        key_d   = KEY_MAP[row_q][col_q];
                        kv_d    = 1'b1;
                        state_d = HOLD;
                    end else if (row_low) begin
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        col_d   = col_q + 2'd1;
                        state_d = SCAN;
                    end
                end
                HOLD: begin
                    if (!row_low) begin
                        cnt_d   = '0;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!row_low && cnt_q == CNT_LAST) begin
                        col_d   = col_q + 2'd1;
                        state_d = SCAN;
                    end else if (!row_low) begin
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SCAN;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            kv_q    <= kv_d;
        end
    end

    assign cols      = ~(4'b0001 << col_q);
    assign key       = key_q;
    assign key_valid = kv_q;
    assign key_held  = (state_q == HOLD) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios with constant expectations
// plus a randomized run checked against a tick-level behavioural model.
module tb_keypad_scanner;

    localparam int DT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_tick;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    int vectors = 0;
    int errors  = 0;
    int pulses  = 0;

    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scanner #(.DEBOUNCE_TICKS(DT)) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_tick (scan_tick),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] col_drive(input int c);
        logic [3:0] v;
        v = 4'b0001 << (c % 4);
        return ~v;
    endfunction

    // One 10-cycle scan period; counts key_valid samples seen in the window.
    task automatic do_tick();
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            pulses += int'(key_valid);
        end
        scan_tick = 1'b1;
        @(negedge clk);
        scan_tick = 1'b0;
        pulses += int'(key_valid);
        repeat (5) begin
            @(negedge clk);
            pulses += int'(key_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; scan_tick = 1'b0; rows = 4'hF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (cols !== 4'b1110) begin errors++; $display("FAIL reset_cols: got %b want 1110", cols); end
        vectors++; if (key !== 4'h0) begin errors++; $display("FAIL reset_key: got %h want 0", key); end
        vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_kv: got %b want 0", key_valid); end
        vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b want 0", key_held); end
    endtask

    task automatic test_idle_scan();
        rows = 4'hF;
        for (int i = 0; i < 8; i++) begin
            do_tick();
            vectors++; if (cols !== col_drive(i + 1)) begin errors++; $display("FAIL idle_cols[%0d]: got %b want %b", i, cols, col_drive(i + 1)); end
            vectors++; if (pulses !== 0) begin errors++; $display("FAIL idle_kv[%0d]: got %0d pulses want 0", i, pulses); end
        end
    endtask

    task automatic test_clean_press();
        int total;
        do_tick(); do_tick();
        vectors++; if (cols !== 4'b1011) begin errors++; $display("FAIL press_setup_cols: got %b want 1011", cols); end
        rows = 4'b1101;
        do_tick();
        vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL press_capture_held: got %b want 0", key_held); end
        total = pulses;
        for (int i = 0; i < DT - 1; i++) begin
            do_tick();
            total += pulses;
        end
        vectors++; if (total !== 0) begin errors++; $display("FAIL press_early_kv: got %0d pulses want 0", total); end
        do_tick();
        vectors++; if (pulses !== 1) begin errors++; $display("FAIL press_kv: got %0d pulses want 1", pulses); end
        vectors++; if (key !== 4'h6) begin errors++; $display("FAIL press_key: got %h want 6", key); end
        vectors++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b want 1", key_held); end
        do_tick();
        vectors++; if (pulses !== 0) begin errors++; $display("FAIL press_second_kv: got %0d pulses want 0", pulses); end
        vectors++; if (cols !== 4'b1011) begin errors++; $display("FAIL press_frozen_cols: got %b want 1011", cols); end
    endtask

    task automatic test_hold_bounce();
        int total;
        rows = 4'hF;
        do_tick(); do_tick();
        vectors++; if (key_held !== 1'b1) begin errors++; $display("FAIL bounce_held_hi: got %b want 1", key_held); end
        total = 0;
        rows = 4'b1101; do_tick(); total += pulses;
        rows = 4'b1100; do_tick(); total += pulses;
        vectors++; if (total !== 0) begin errors++; $display("FAIL bounce_kv: got %0d pulses want 0", total); end
        vectors++; if (key !== 4'h6) begin errors++; $display("FAIL bounce_key: got %h want 6", key); end
        vectors++; if (cols !== 4'b1011) begin errors++; $display("FAIL bounce_cols: got %b want 1011", cols); end
        rows = 4'hF;
        for (int i = 0; i < DT; i++) do_tick();
        vectors++; if (key_held !== 1'b1) begin errors++; $display("FAIL release_early_held: got %b want 1", key_held); end
        do_tick();
        vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_held: got %b want 0", key_held); end
        vectors++; if (cols !== 4'b0111) begin errors++; $display("FAIL release_cols: got %b want 0111", cols); end
    endtask

    task automatic test_short_press();
        int total;
        rows = 4'hF;
        do_tick(); do_tick(); do_tick();
        total = 0;
        rows = 4'b1101; do_tick(); total += pulses;
        do_tick(); total += pulses;
        rows = 4'hF; do_tick(); total += pulses;
        vectors++; if (total !== 0) begin errors++; $display("FAIL short_kv: got %0d pulses want 0", total); end
        vectors++; if (cols !== 4'b0111) begin errors++; $display("FAIL short_cols: got %b want 0111", cols); end
        vectors++; if (key_held !== 1'b0) begin errors++; $display("FAIL short_held: got %b want 0", key_held); end
    endtask

    task automatic test_multi_row();
        rows = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            do_tick();
            vectors++; if (cols !== col_drive(i)) begin errors++; $display("FAIL multi_cols[%0d]: got %b want %b", i, cols, col_drive(i)); end
            vectors++; if (key_held !== 1'b0 || pulses !== 0) begin errors++; $display("FAIL multi_capture[%0d]: held %b pulses %0d want 0 0", i, key_held, pulses); end
        end
    endtask

    task automatic test_reset_mid_debounce();
        int total;
        rows = 4'b1110;
        do_tick(); do_tick(); do_tick();
        repeat (4) @(negedge clk);
        scan_tick = 1'b1; reset = 1'b1; rows = 4'b0111;
        @(negedge clk);
        scan_tick = 1'b0; reset = 1'b0;
        vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL abort_kv: got %b want 0", key_valid); end
        vectors++; if (key !== 4'h0) begin errors++; $display("FAIL abort_key: got %h want 0", key); end
        vectors++; if (cols !== 4'b1110) begin errors++; $display("FAIL abort_cols: got %b want 1110", cols); end
        total = 0;
        for (int i = 0; i < DT; i++) begin
            do_tick();
            total += pulses;
        end
        vectors++; if (total !== 0) begin errors++; $display("FAIL abort_early_kv: got %0d pulses want 0", total); end
        do_tick();
        vectors++; if (pulses !== 1) begin errors++; $display("FAIL after_abort_kv: got %0d pulses want 1", pulses); end
        vectors++; if (key !== 4'hE) begin errors++; $display("FAIL after_abort_key: got %h want E", key); end
        rows = 4'hF;
        for (int i = 0; i < DT + 1; i++) do_tick();
        vectors++; if (key_held !== 1'b0 || cols !== 4'b1101) begin errors++; $display("FAIL after_abort_release: held %b cols %b want 0 1101", key_held, cols); end
    endtask

    task automatic test_random();
        int         m_col, m_row, m_run, exp_pulse, nlow;
        bit         m_lock, m_acc;
        logic [3:0] m_key, rv, pick;
        rows = 4'hF; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_col = 0; m_row = 0; m_run = 0; m_lock = 0; m_acc = 0; m_key = 4'h0;
        rv = 4'hF;
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 9) >= 7) begin
                pick = 4'($urandom_range(0, 15));
                case ($urandom_range(0, 4))
                    0, 1:    rv = 4'hF;
                    2, 3:    rv = ~(4'b0001 << pick[1:0]);
                    default: rv = pick;
                endcase
            end
            rows = rv;
            do_tick();
            // Model: DT low ticks after capture accept; DT+1 high ticks release.
            exp_pulse = 0;
            nlow = $countones(~rv);
            if (!m_lock) begin
                if (nlow == 1) begin
                    m_lock = 1; m_acc = 0; m_run = 0;
                    for (int b = 0; b < 4; b++) if (!rv[b]) m_row = b;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else if (!m_acc) begin
                if (!rv[m_row]) begin
                    m_run++;
                    if (m_run == DT) begin
                        m_acc = 1; m_run = 0; m_key = keymap[m_row * 4 + m_col]; exp_pulse = 1;
                    end
                end else begin
                    m_lock = 0; m_col = (m_col + 1) % 4;
                end
            end else begin
                if (!rv[m_row]) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == DT + 1) begin
                        m_acc = 0; m_lock = 0; m_run = 0; m_col = (m_col + 1) % 4;
                    end
                end
            end
            vectors++; if (cols !== col_drive(m_col)) begin errors++; $display("FAIL rand_cols[%0d]: got %b want %b", t, cols, col_drive(m_col)); end
            vectors++; if (key_held !== m_acc) begin errors++; $display("FAIL rand_held[%0d]: got %b want %b", t, key_held, m_acc); end
            vectors++; if (key !== m_key) begin errors++; $display("FAIL rand_key[%0d]: got %h want %h", t, key, m_key); end
            vectors++; if (pulses !== exp_pulse) begin errors++; $display("FAIL rand_kv[%0d]: got %0d pulses want %0d", t, pulses, exp_pulse); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_clean_press();
        test_hold_bounce();
        test_short_press();
        test_multi_row();
        test_reset_mid_debounce();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
